// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-transfer master: each accepted command becomes one NONSEQ SINGLE transfer.
// Define AHB_CMD_MASTER_TIMEOUT_EN to abort transfers stalled for TIMEOUT wait cycles.
module ahb_cmd_master #(
  parameter int AWIDTH  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [AWIDTH-1:0] CMD_ADDR,
  input  logic [1:0]        CMD_SIZE,
  input  logic [31:0]       CMD_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERROR,
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic [31:0]       HRDATA,
  input  logic              HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  state_t              state_q;
  logic                ready_q;
  logic [AWIDTH-1:0]   haddr_q;
  logic [1:0]          htrans_q;
  logic                hwrite_q;
  logic [2:0]          hsize_q;
  logic [31:0]         hwdata_q;
  logic [31:0]         wdata_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_error_q;

  // A zero limit would make the watchdog fire before any wait state is seen.
  if (TIMEOUT < 1) begin : g_timeout_range
    $error("ahb_cmd_master: TIMEOUT must be at least 1");
  end

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);

  logic [TW-1:0] wait_cnt_q;

  // Reloaded whenever the bus moves (or we are idle), so it only sees consecutive stalls.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wait_cnt_q <= TO_LOAD;
    end else if (state_q == ST_IDLE || HREADY) begin
      wait_cnt_q <= TO_LOAD;
    end else if (wait_cnt_q != '0) begin
      wait_cnt_q <= wait_cnt_q - 1'b1;
    end
  end
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      haddr_q     <= '0;
      htrans_q    <= TRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      hwdata_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && CMD_VALID) begin
            ready_q  <= 1'b0;
            htrans_q <= TRANS_NONSEQ;
            haddr_q  <= CMD_ADDR;
            hwrite_q <= CMD_WRITE;
            hsize_q  <= (CMD_SIZE == 2'd3) ? 3'b010 : {1'b0, CMD_SIZE};
            wdata_q  <= CMD_WDATA;
            state_q  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            htrans_q <= TRANS_IDLE;
            if (hwrite_q) hwdata_q <= wdata_q;
            state_q  <= ST_DATA;
          end
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
          else if (wait_cnt_q == '0) begin
            htrans_q    <= TRANS_IDLE;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            rsp_rdata_q <= '0;
            ready_q     <= 1'b1;
            state_q     <= ST_IDLE;
          end
`endif
        end
        ST_DATA: begin
          // HRESP alone is the first cycle of a two-cycle ERROR; wait for HREADY.
          if (HREADY) begin
            rsp_valid_q <= 1'b1;
            rsp_error_q <= HRESP;
            rsp_rdata_q <= hwrite_q ? 32'h0 : HRDATA;
            ready_q     <= 1'b1;
            state_q     <= ST_IDLE;
          end
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
          else if (wait_cnt_q == '0) begin
            htrans_q    <= TRANS_IDLE;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            rsp_rdata_q <= '0;
            ready_q     <= 1'b1;
            state_q     <= ST_IDLE;
          end
`endif
        end
        default: begin
          htrans_q <= TRANS_IDLE;
          ready_q  <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign CMD_READY = ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERROR = rsp_error_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: procedural slave per transfer, response scoreboard keyed by cycle.
// Build with or without AHB_CMD_MASTER_TIMEOUT_EN; the stall test adapts.
module tb_ahb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WRITE = 1'b0;
  logic [31:0] CMD_ADDR = '0;
  logic [1:0]  CMD_SIZE = '0;
  logic [31:0] CMD_WDATA = '0;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERROR;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA = '0;
  logic        HRESP = 1'b0;

  ahb_cmd_master #(.AWIDTH(32), .TIMEOUT(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_SIZE(CMD_SIZE), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERROR(RSP_ERROR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t exp_q[$];

  always @(negedge HCLK) begin : rsp_monitor
    exp_t e;
    if (RSP_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        chk("rsp_rdata", 64'(RSP_RDATA), 64'(e.rdata));
        chk("rsp_error", 64'(RSP_ERROR), 64'(e.err));
        chk("hburst", 64'(HBURST), 64'd0);
        chk("hprot", 64'(HPROT), 64'h3);
        chk("hmastlock", 64'(HMASTLOCK), 64'd0);
      end
    end
  end

  // Drives one command and plays the slave: aw/dw wait states in address/data phase.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [1:0] sz,
                      input logic [31:0] wd, input int aw, input int dw,
                      input logic [31:0] rd, input bit err, input bit hold,
                      output int k);
    exp_t       e;
    logic [2:0] esz;
    esz = (sz == 2'd3) ? 3'b010 : {1'b0, sz};
    chk("cmd_ready_idle", 64'(CMD_READY), 64'd1);
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_SIZE = sz; CMD_WDATA = wd;
    HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    k = cyc;
    e.cyc = k + 2 + aw + dw;
    e.rdata = wr ? 32'h0 : rd;
    e.err = err;
    exp_q.push_back(e);
    if (!hold) begin
      CMD_VALID = 1'b0;
      CMD_WDATA = ~wd;
    end
    chk("addr_htrans", 64'(HTRANS), 64'h2);
    chk("addr_haddr", 64'(HADDR), 64'(addr));
    chk("addr_hwrite", 64'(HWRITE), 64'(wr));
    chk("addr_hsize", 64'(HSIZE), 64'(esz));
    chk("busy_ready", 64'(CMD_READY), 64'd0);
    for (int i = 0; i < aw; i++) begin
      HREADY = 1'b0;
      @(negedge HCLK);
      chk("addr_hold_htrans", 64'(HTRANS), 64'h2);
      chk("addr_hold_haddr", 64'(HADDR), 64'(addr));
      chk("addr_hold_hsize", 64'(HSIZE), 64'(esz));
    end
    HREADY = 1'b1;
    @(negedge HCLK);
    chk("data_htrans", 64'(HTRANS), 64'h0);
    if (wr) chk("data_hwdata", 64'(HWDATA), 64'(wd));
    for (int j = 0; j < dw; j++) begin
      HREADY = 1'b0;
      HRESP  = err && (j == dw - 1);
      HRDATA = ~rd;
      @(negedge HCLK);
      chk("wait_htrans", 64'(HTRANS), 64'h0);
      chk("wait_no_rsp", 64'(RSP_VALID), 64'd0);
      if (wr) chk("wait_hwdata", 64'(HWDATA), 64'(wd));
    end
    HREADY = 1'b1; HRESP = err; HRDATA = rd;
    @(negedge HCLK);
    chk("rsp_valid", 64'(RSP_VALID), 64'd1);
    HRESP = 1'b0; HRDATA = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k, k1, k2, seen;
    repeat (3) @(negedge HCLK);
    chk("rst_htrans", 64'(HTRANS), 64'h0);
    chk("rst_haddr", 64'(HADDR), 64'h0);
    chk("rst_hsize", 64'(HSIZE), 64'h0);
    chk("rst_hwdata", 64'(HWDATA), 64'h0);
    chk("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
    chk("rst_ready", 64'(CMD_READY), 64'd0);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("release_ready", 64'(CMD_READY), 64'd1);

    xfer(1'b1, 32'h40, 2'd2, 32'h1234_5678, 0, 0, 32'h0, 1'b0, 1'b0, k);
    xfer(1'b0, 32'h44, 2'd2, 32'h0, 0, 2, 32'hCAFE_F00D, 1'b0, 1'b0, k);
    xfer(1'b0, 32'h48, 2'd2, 32'h0, 0, 1, 32'h5555_AAAA, 1'b1, 1'b0, k);

    // Reset while a write is stalled in its data phase.
    @(negedge HCLK);
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h80; CMD_SIZE = 2'd2;
    CMD_WDATA = 32'hDEAD_BEEF; HREADY = 1'b1;
    @(negedge HCLK);
    CMD_VALID = 1'b0;
    @(negedge HCLK);
    HREADY = 1'b0;
    chk("pre_rst_hwdata", 64'(HWDATA), 64'hDEAD_BEEF);
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0; HREADY = 1'b1;
    chk("mid_rst_htrans", 64'(HTRANS), 64'h0);
    chk("mid_rst_haddr", 64'(HADDR), 64'h0);
    chk("mid_rst_hwrite", 64'(HWRITE), 64'h0);
    chk("mid_rst_hwdata", 64'(HWDATA), 64'h0);
    chk("mid_rst_rsp_valid", 64'(RSP_VALID), 64'd0);
    chk("mid_rst_rsp_rdata", 64'(RSP_RDATA), 64'h0);
    chk("mid_rst_rsp_error", 64'(RSP_ERROR), 64'h0);
    chk("mid_rst_ready", 64'(CMD_READY), 64'd0);
    repeat (3) @(negedge HCLK);
    chk("post_rst_ready", 64'(CMD_READY), 64'd1);

    xfer(1'b1, 32'h100, 2'd2, 32'hA5A5_0001, 0, 0, 32'h0, 1'b0, 1'b1, k1);
    xfer(1'b1, 32'h104, 2'd2, 32'h5A5A_0002, 0, 0, 32'h0, 1'b0, 1'b0, k2);
    chk("b2b_no_gap", 64'(k2), 64'(k1 + 3));

    xfer(1'b0, 32'h13, 2'd3, 32'h0, 2, 0, 32'h0BAD_CAFE, 1'b0, 1'b0, k);
    xfer(1'b1, 32'h13, 2'd0, 32'hAB00_0000, 1, 1, 32'h0, 1'b0, 1'b0, k);
    xfer(1'b0, 32'h22, 2'd1, 32'h0, 1, 3, 32'h0000_BEEF, 1'b1, 1'b0, k);

    // Slave that never becomes ready.
    @(negedge HCLK);
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h200; CMD_SIZE = 2'd2;
    HREADY = 1'b0;
    @(negedge HCLK);
    CMD_VALID = 1'b0;
    k = cyc;
    seen = 0;
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
    begin
      exp_t e;
      e.cyc = k + 8; e.rdata = 32'h0; e.err = 1'b1;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge HCLK);
      if (RSP_VALID === 1'b1) seen = 1;
    end
    chk("timeout_rsp", 64'(seen), 64'd1);
    chk("timeout_htrans", 64'(HTRANS), 64'h0);
    chk("timeout_ready", 64'(CMD_READY), 64'd1);
`else
    for (int i = 0; i < 1000; i++) begin
      @(negedge HCLK);
      if (RSP_VALID === 1'b1) seen++;
    end
    chk("hang_no_rsp", 64'(seen), 64'd0);
    chk("hang_htrans", 64'(HTRANS), 64'h2);
    chk("hang_ready", 64'(CMD_READY), 64'd0);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
`endif
    HREADY = 1'b1;
    repeat (3) @(negedge HCLK);
    xfer(1'b0, 32'h300, 2'd2, 32'h0, 0, 0, 32'h1357_9BDF, 1'b0, 1'b0, k);
    repeat (2) @(negedge HCLK);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
